fetch_stage: RTL

Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the decode stage. It holds the PC and a loadable 128x32 instruction memory, and drives the instruction and the PC of the next instruction into decode. It consumes decode's redirect, target, stall and halt outputs, and also provides a program-load port and cycle/PC visibility for the debug unit.

---
 rtl/fetch_stage.sv | 63 ++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC, loadable instruction memory and IF/ID register feeding decode.
module fetch_stage #(
  parameter int NB_DATA   = 32,
  parameter int NB_PC     = 7,
  parameter int MEM_DEPTH = 128
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               stall_i,
  input  logic               pc_branch_or_jump_i,
  input  logic [1:0]         pc_src_i,
  input  logic [NB_PC-1:0]   address_branch_i,
  input  logic [NB_PC-1:0]   address_jump_i,
  input  logic [NB_PC-1:0]   address_register_i,
  input  logic               halt_i,
  input  logic               load_en_i,
  input  logic [NB_PC-1:0]   load_addr_i,
  input  logic [NB_DATA-1:0] load_data_i,
  output logic [NB_DATA-1:0] instruction_o,
  output logic [NB_PC-1:0]   pc_decode_o,
  output logic [NB_PC-1:0]   pc_o,
  output logic               halted_o,
  output logic [31:0]        cycle_count_o
);
  logic [NB_DATA-1:0] mem [MEM_DEPTH];
  logic [NB_PC-1:0]   pc;
  logic [NB_PC-1:0]   target;
  logic [NB_PC-1:0]   pc_inc;
  always_comb begin
    target = pc_src_i == 2'b01 ? address_jump_i :
             pc_src_i == 2'b10 ? address_register_i : address_branch_i;
    pc_inc = pc + 1'b1;
  end
  assign pc_o = pc;
  always_ff @(posedge clock_i)
    if (load_en_i) mem[load_addr_i] <= load_data_i;
  // A stall counts as an advanced cycle but freezes pc and IF/ID, ignoring redirect/halt.
  always_ff @(posedge clock_i or negedge reset_i)
    if (!reset_i) begin
      pc            <= '0;
      instruction_o <= '0;
      pc_decode_o   <= '0;
      halted_o      <= 1'b0;
      cycle_count_o <= '0;
    end else if (!load_en_i && enable_i && !halted_o) begin
      cycle_count_o <= cycle_count_o + 32'd1;
      if (!stall_i) begin
        if (halt_i) begin
          halted_o      <= 1'b1;
          instruction_o <= '0;
        end else if (pc_branch_or_jump_i) begin
          pc            <= target;
          instruction_o <= '0;
          pc_decode_o   <= '0;
        end else begin
          instruction_o <= mem[pc];
          pc_decode_o   <= pc_inc;
          pc            <= pc_inc;
        end
      end
    end
endmodule
